// File: rtl/muller_hs_pkg.sv
// rtl/muller_hs_pkg.sv - shared types and constants for the 4-phase handshake sender
// Purpose: handshake FSM state encoding and the completed-transfer counter width.
// Ports: none (package).
package muller_hs_pkg;

  localparam int SENT_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    REQ_HI = 3'd2,
    REQ_LO = 3'd3,
    ERR    = 3'd4
  } hs_state_t;

endpackage

// File: rtl/muller_hs_sync.sv
// rtl/muller_hs_sync.sv - multi-flop synchronizer for a single asynchronous bit
// Purpose: brings the asynchronous acknowledge into the clock domain.
// Ports:
//   clk_i : clock, all state on rising edge
//   rst_i : synchronous active-high reset, clears the chain to 0
//   d_i   : asynchronous input bit
//   q_o   : synchronized output, STAGES edges behind d_i
module muller_hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/muller_c_hs_sender.sv
// rtl/muller_c_hs_sender.sv - clocked initiator of a 4-phase RZ bundled-data handshake
// Purpose: buffers words from synchronous logic in a small FIFO and sends each one
//   to an asynchronous C-element stage with req_o/data_o, completing on ack rise+fall.
// Ports:
//   wb_clk_i, wb_rst_i        : clock and synchronous active-high reset
//   in_valid, in_ready, in_data : producer push side (in_ready = FIFO not full)
//   req_o, data_o, ack_i      : 4-phase request, bundled data, asynchronous acknowledge
//   busy                      : FSM not idle or FIFO non-empty
//   sent_count                : completed transfers, wraps
//   timeout_err               : sticky watchdog flag
// Optional feature: MULLER_HS_TIMEOUT_EN adds a handshake watchdog and the ERR state;
//   without it the FSM waits indefinitely and timeout_err is tied 0.
import muller_hs_pkg::*;

module muller_c_hs_sender #(
  parameter int DATA_W      = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  req_o,
  output logic [DATA_W-1:0]     data_o,
  input  logic                  ack_i,
  output logic                  busy,
  output logic [SENT_CNT_W-1:0] sent_count,
  output logic                  timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]            PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [SENT_CNT_W-1:0] CNT_ONE = {{(SENT_CNT_W-1){1'b0}}, 1'b1};

  logic ack_s;

  muller_hs_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .d_i   (ack_i),
    .q_o   (ack_s)
  );

  // FIFO: pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              full, empty, push, pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  hs_state_t                 state_q, state_d;
  logic                      req_q, req_d;
  logic [DATA_W-1:0]         data_q, data_d;
  logic [SENT_CNT_W-1:0]     cnt_q, cnt_d;
  logic                      wd_expire;

`ifdef MULLER_HS_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  // The edge that would take the counter to all-ones is the edge that enters ERR.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 in_hs, timeout_err_q;

  assign in_hs     = (state_q == REQ_HI) || (state_q == REQ_LO);
  assign wd_expire = in_hs && (wd_q == WD_LAST);

  always_comb begin
    wd_d = wd_q;
    if ((state_d == REQ_HI || state_d == REQ_LO) && (state_d != state_q)) begin
      wd_d = '0;
    end else if (in_hs) begin
      wd_d = wd_q + WD_ONE;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (wd_expire) timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  localparam int unused_timeout_w = TIMEOUT_W;
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic. A stale high ack keeps IDLE from starting a new transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty && !ack_s) state_d = SETUP;
      SETUP:   state_d = REQ_HI;
      REQ_HI:  if (ack_s)  state_d = REQ_LO;
      REQ_LO:  if (!ack_s) state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    // Watchdog expiry wins over an ack arriving in the same cycle.
    if (wd_expire) state_d = ERR;
  end

  // Output logic: next values of the registered handshake outputs.
  always_comb begin
    req_d  = req_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !ack_s) begin
          pop    = 1'b1;
          data_d = mem_q[rd_ptr_q[AW-1:0]];
        end
      end
      SETUP:   req_d = 1'b1;
      REQ_HI:  if (ack_s)  req_d = 1'b0;
      REQ_LO:  if (!ack_s) cnt_d = cnt_q + CNT_ONE;
      default: req_d = 1'b0;
    endcase
    if (wd_expire) begin
      req_d = 1'b0;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      req_q  <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      req_q  <= req_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign req_o      = req_q;
  assign data_o     = data_q;
  assign sent_count = cnt_q;
  assign busy       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_muller_c_hs_sender.sv
// tb/tb_muller_c_hs_sender.sv - directed self-checking bench for muller_c_hs_sender
module tb_muller_c_hs_sender;

  localparam int DATA_W      = 4;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              req_o;
  logic [DATA_W-1:0] data_o;
  logic              ack_i;
  logic              busy;
  logic [7:0]        sent_count;
  logic              timeout_err;

  logic              resp_en;
  logic              ack_man;
  logic [2:0]        dly;

  int n_checks = 0;
  int n_pass   = 0;

  muller_c_hs_sender #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .req_o       (req_o),
    .data_o      (data_o),
    .ack_i       (ack_i),
    .busy        (busy),
    .sent_count  (sent_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Echoing responder: ack follows req three falling edges later.
  always @(negedge clk) begin
    if (resp_en) dly = {dly[1:0], req_o};
    else         dly = 3'b000;
  end
  assign ack_i = resp_en ? dly[2] : ack_man;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; resp_en = 1'b0; ack_man = 1'b0;
    step(2);
    n_checks++; if (req_o !== 1'b0) $display("FAIL reset_req: req_o=%b expected 0", req_o); else n_pass++;
    n_checks++; if (data_o !== 4'h0) $display("FAIL reset_data: data_o=%h expected 0", data_o); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: in_ready=%b expected 1", in_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b expected 0", busy); else n_pass++;
    n_checks++; if (sent_count !== 8'd0) $display("FAIL reset_count: sent_count=%0d expected 0", sent_count); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout: timeout_err=%b expected 0", timeout_err); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    do_reset();
    in_valid = 1'b1; in_data = 4'hA;
    step(1);
    in_valid = 1'b0;
    n_checks++; if (data_o !== 4'h0 || req_o !== 1'b0) $display("FAIL t1_edge0: data_o=%h req_o=%b expected 0 0", data_o, req_o); else n_pass++;
    step(1);
    n_checks++; if (data_o !== 4'hA || req_o !== 1'b0) $display("FAIL t1_edge1: data_o=%h req_o=%b expected a 0", data_o, req_o); else n_pass++;
    step(1);
    n_checks++; if (req_o !== 1'b1) $display("FAIL t1_req_rise: req_o=%b expected 1", req_o); else n_pass++;
    step(3);
    ack_man = 1'b1;
    step(2);
    n_checks++; if (req_o !== 1'b1) $display("FAIL t1_req_hold_sync: req_o=%b expected 1", req_o); else n_pass++;
    step(1);
    n_checks++; if (req_o !== 1'b0) $display("FAIL t1_req_fall: req_o=%b expected 0", req_o); else n_pass++;
    ack_man = 1'b0;
    step(2);
    n_checks++; if (sent_count !== 8'd0) $display("FAIL t1_count_early: sent_count=%0d expected 0", sent_count); else n_pass++;
    step(1);
    n_checks++; if (sent_count !== 8'd1) $display("FAIL t1_count: sent_count=%0d expected 1", sent_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL t1_busy: busy=%b expected 0", busy); else n_pass++;
    n_checks++; if (data_o !== 4'hA) $display("FAIL t1_data_held: data_o=%h expected a", data_o); else n_pass++;
  endtask

  task automatic test_burst();
    logic [3:0] got [4];
    int k;
    logic prev;
    do_reset();
    ack_man = 1'b1;
    step(3);
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      step(1);
    end
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL t2_full: in_ready=%b expected 0", in_ready); else n_pass++;
    n_checks++; if (req_o !== 1'b0 || data_o !== 4'h0) $display("FAIL t2_stale_ack: req_o=%b data_o=%h expected 0 0", req_o, data_o); else n_pass++;
    resp_en = 1'b1;
    step(2);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL t2_full_hold: in_ready=%b expected 0", in_ready); else n_pass++;
    step(1);
    n_checks++; if (in_ready !== 1'b1 || data_o !== 4'h1) $display("FAIL t2_first_pop: in_ready=%b data_o=%h expected 1 1", in_ready, data_o); else n_pass++;
    for (int i = 0; i < 4; i++) got[i] = 4'h0;
    k = 0;
    prev = req_o;
    for (int c = 0; c < 400 && !(sent_count == 8'd4 && busy == 1'b0); c++) begin
      step(1);
      if (req_o && !prev && k < 4) begin
        got[k] = data_o;
        k++;
      end
      prev = req_o;
    end
    n_checks++; if (k != 4) $display("FAIL t2_req_pulses: saw %0d expected 4", k); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got[i] !== 4'(i + 1)) $display("FAIL t2_data_seq[%0d]: data_o=%h expected %h", i, got[i], 4'(i + 1));
      else n_pass++;
    end
    n_checks++; if (sent_count !== 8'd4) $display("FAIL t2_count: sent_count=%0d expected 4", sent_count); else n_pass++;
    resp_en = 1'b0;
  endtask

  task automatic test_backpressure();
    int c;
    do_reset();
    ack_man = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 4'(6 + i);
      step(1);
    end
    n_checks++; if (in_ready !== 1'b0) $display("FAIL t3_full: in_ready=%b expected 0", in_ready); else n_pass++;
    in_data = 4'hB;
    step(4);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL t3_refuse: in_ready=%b expected 0", in_ready); else n_pass++;
    n_checks++; if (req_o !== 1'b1 || data_o !== 4'h6) $display("FAIL t3_in_flight: req_o=%b data_o=%h expected 1 6", req_o, data_o); else n_pass++;
    in_valid = 1'b0;
    resp_en = 1'b1;
    c = 0;
    while (busy && c < 500) begin step(1); c++; end
    n_checks++; if (sent_count !== 8'd5) $display("FAIL t3_count: sent_count=%0d expected 5", sent_count); else n_pass++;
    resp_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    ack_man = 1'b0;
    in_valid = 1'b1; in_data = 4'hC; step(1);
    in_data = 4'hD; step(1);
    in_valid = 1'b0;
    step(1);
    n_checks++; if (req_o !== 1'b1) $display("FAIL t4_pre_req: req_o=%b expected 1", req_o); else n_pass++;
    ack_man = 1'b1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_checks++; if (req_o !== 1'b0) $display("FAIL t4_req_drop: req_o=%b expected 0", req_o); else n_pass++;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL t4_fifo_flush: busy=%b in_ready=%b expected 0 1", busy, in_ready); else n_pass++;
    step(3);
    in_valid = 1'b1; in_data = 4'h5; step(1);
    in_valid = 1'b0;
    step(6);
    n_checks++; if (req_o !== 1'b0 || busy !== 1'b1) $display("FAIL t4_blocked: req_o=%b busy=%b expected 0 1", req_o, busy); else n_pass++;
    ack_man = 1'b0;
    n = 0;
    while (req_o !== 1'b1 && n < 20) begin step(1); n++; end
    n_checks++;
    if (n < SYNC_STAGES + 2 || n > SYNC_STAGES + 3) $display("FAIL t4_req_latency: edges=%0d expected %0d..%0d", n, SYNC_STAGES + 2, SYNC_STAGES + 3);
    else n_pass++;
    n_checks++; if (data_o !== 4'h5) $display("FAIL t4_data: data_o=%h expected 5", data_o); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    resp_en = 1'b0; ack_man = 1'b0;
    in_valid = 1'b1; in_data = 4'hE; step(1);
    in_valid = 1'b0;
    step(1);
    n_checks++; if (req_o !== 1'b0) $display("FAIL t5_setup: req_o=%b expected 0", req_o); else n_pass++;
    step(1);
    n_checks++; if (req_o !== 1'b1) $display("FAIL t5_req_hi: req_o=%b expected 1", req_o); else n_pass++;
`ifdef MULLER_HS_TIMEOUT_EN
    step(14);
    n_checks++; if (req_o !== 1'b1 || timeout_err !== 1'b0) $display("FAIL t5_before_expiry: req_o=%b timeout_err=%b expected 1 0", req_o, timeout_err); else n_pass++;
    step(1);
    n_checks++; if (req_o !== 1'b0 || timeout_err !== 1'b1) $display("FAIL t5_expiry: req_o=%b timeout_err=%b expected 0 1", req_o, timeout_err); else n_pass++;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin in_data = 4'(i); step(1); end
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL t5_fifo_fills: in_ready=%b expected 0", in_ready); else n_pass++;
    step(10);
    n_checks++; if (req_o !== 1'b0 || timeout_err !== 1'b1) $display("FAIL t5_sticky: req_o=%b timeout_err=%b expected 0 1", req_o, timeout_err); else n_pass++;
    do_reset();
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL t5_reset_clears: timeout_err=%b expected 0", timeout_err); else n_pass++;
`else
    step(15);
    n_checks++; if (req_o !== 1'b1 || timeout_err !== 1'b0) $display("FAIL t5_no_watchdog: req_o=%b timeout_err=%b expected 1 0", req_o, timeout_err); else n_pass++;
    step(10);
    n_checks++; if (req_o !== 1'b1 || timeout_err !== 1'b0) $display("FAIL t5_no_watchdog_hold: req_o=%b timeout_err=%b expected 1 0", req_o, timeout_err); else n_pass++;
    do_reset();
`endif
  endtask

  task automatic push_when_ready(input logic [3:0] d);
    int g;
    g = 0;
    while (in_ready !== 1'b1 && g < 200) begin step(1); g++; end
    in_valid = 1'b1; in_data = d;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    int c;
    do_reset();
    resp_en = 1'b1;
    for (int i = 0; i < 255; i++) push_when_ready(4'(i));
    c = 0;
    while (busy && c < 5000) begin step(1); c++; end
    n_checks++; if (sent_count !== 8'd255) $display("FAIL t6_count_255: sent_count=%0d expected 255", sent_count); else n_pass++;
    push_when_ready(4'h9);
    c = 0;
    while (busy && c < 200) begin step(1); c++; end
    n_checks++; if (sent_count !== 8'd0) $display("FAIL t6_wrap: sent_count=%0d expected 0", sent_count); else n_pass++;
    n_checks++; if (data_o !== 4'h9) $display("FAIL t6_last_data: data_o=%h expected 9", data_o); else n_pass++;
    resp_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: run exceeded 2000000 time units");
    $fatal(1);
  end

endmodule
